// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter: mode constants and a
// width-independent next-count function usable by RTL and reference models.
package counter_pkg;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    typedef struct packed {
        longint unsigned count;
        logic            tc;
    } cnt_step_t;

    // One counting step (no load) over the range 0 .. modulus-1.
    // Conflicting or absent requests hold the count with tc low.
    function automatic cnt_step_t cnt_next(input longint unsigned count,
                                           input logic            up,
                                           input logic            down,
                                           input longint unsigned modulus,
                                           input bit              mode);
        cnt_step_t res;
        res.count = count;
        res.tc    = 1'b0;
        if (up && !down) begin
            if (count == modulus - 1) begin
                res.tc    = 1'b1;
                res.count = (mode == CNT_SAT) ? count : 64'd0;
            end else begin
                res.count = count + 64'd1;
            end
        end else if (down && !up) begin
            if (count == 64'd0) begin
                res.tc    = 1'b1;
                res.count = (mode == CNT_SAT) ? count : modulus - 1;
            end else begin
                res.count = count - 64'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/updown_counter.sv
// Parametrised load/up/down counter with wrap or saturate at the range ends,
// and registered one-cycle terminal-count and load-error flags.
module updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 3,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             ld_err
);

    // Bad configurations are caught at elaboration time.
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    // Top of range, one bit wider than the count so MODULUS = 2**WIDTH fits cleanly.
    localparam logic [WIDTH:0] MAX_CNT = (WIDTH + 1)'(MODULUS - 64'd1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ld_err_q, ld_err_d;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   din_ext;

    // Next-state: load has priority, then a single-direction step, else hold.
    always_comb begin
        cnt_ext  = {1'b0, cnt_q};
        din_ext  = {1'b0, data_in};
        cnt_d    = cnt_q;
        tc_d     = 1'b0;
        ld_err_d = 1'b0;
        if (ld) begin
            if (din_ext <= MAX_CNT) begin
                cnt_d = data_in;
            end else begin
                cnt_d    = MAX_CNT[WIDTH-1:0];
                ld_err_d = 1'b1;
            end
        end else if (inc && !dec) begin
            if (cnt_ext == MAX_CNT) begin
                tc_d  = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_ext == '0) begin
                tc_d  = 1'b1;
                cnt_d = SATURATE ? cnt_q : MAX_CNT[WIDTH-1:0];
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    // State registers; reset clears count and flags without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            tc_q     <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tc_q     <= tc_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign data_out = cnt_q;
    assign tc       = tc_q;
    assign ld_err   = ld_err_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: default wrap counter, a modulus-10 wrap
// counter and a modulus-10 saturating counter, each with its own inputs.
module tb_updown_counter;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       a_ld = 0, a_inc = 0, a_dec = 0;
    logic [2:0] a_din = '0;
    logic [2:0] a_q;
    logic       a_tc, a_err;

    logic       b_ld = 0, b_inc = 0, b_dec = 0;
    logic [3:0] b_din = '0;
    logic [3:0] b_q;
    logic       b_tc, b_err;

    logic       c_ld = 0, c_inc = 0, c_dec = 0;
    logic [3:0] c_din = '0;
    logic [3:0] c_q;
    logic       c_tc, c_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_counter u_a (
        .clk(clk), .rst(rst), .ld(a_ld), .inc(a_inc), .dec(a_dec),
        .data_in(a_din), .data_out(a_q), .tc(a_tc), .ld_err(a_err)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_b (
        .clk(clk), .rst(rst), .ld(b_ld), .inc(b_inc), .dec(b_dec),
        .data_in(b_din), .data_out(b_q), .tc(b_tc), .ld_err(b_err)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_SAT)) u_c (
        .clk(clk), .rst(rst), .ld(c_ld), .inc(c_inc), .dec(c_dec),
        .data_in(c_din), .data_out(c_q), .tc(c_tc), .ld_err(c_err)
    );

    task automatic check(input string tag, input longint unsigned got,
                         input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one DUT for one edge (others idle), then settle just after the edge.
    task automatic cycle(input int sel, input logic l, input logic i, input logic d,
                         input logic [3:0] din);
        @(negedge clk);
        {a_ld, a_inc, a_dec} = 3'b000; a_din = '0;
        {b_ld, b_inc, b_dec} = 3'b000; b_din = '0;
        {c_ld, c_inc, c_dec} = 3'b000; c_din = '0;
        case (sel)
            0: begin a_ld = l; a_inc = i; a_dec = d; a_din = din[2:0]; end
            1: begin b_ld = l; b_inc = i; b_dec = d; b_din = din; end
            default: begin c_ld = l; c_inc = i; c_dec = d; c_din = din; end
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint unsigned exp_cnt;
        cnt_step_t       m;

        // Reset state while rst is held low.
        #3;
        check("rst_a_q", a_q, 0);
        check("rst_a_tc", a_tc, 0);
        check("rst_b_err", b_err, 0);
        check("rst_c_q", c_q, 0);
        @(negedge clk);
        rst = 1'b1;

        // Default counter: ten increments wrap 7 -> 0 once.
        for (int k = 1; k <= 10; k++) begin
            cycle(0, 1'b0, 1'b1, 1'b0, 4'd0);
            check($sformatf("a_inc_q%0d", k), a_q, k % 8);
            check($sformatf("a_inc_tc%0d", k), a_tc, (k == 8) ? 1 : 0);
        end

        // Simultaneous inc and dec hold the count.
        cycle(0, 1'b1, 1'b0, 1'b0, 4'd5);
        check("a_ld5", a_q, 5);
        cycle(0, 1'b0, 1'b1, 1'b1, 4'd0);
        check("a_both_q", a_q, 5);
        check("a_both_tc", a_tc, 0);

        // Modulus 10, wrap mode.
        cycle(1, 1'b1, 1'b0, 1'b0, 4'd9);
        check("b_ld9_q", b_q, 9);
        check("b_ld9_err", b_err, 0);
        cycle(1, 1'b0, 1'b1, 1'b0, 4'd0);
        check("b_wrapup_q", b_q, 0);
        check("b_wrapup_tc", b_tc, 1);
        cycle(1, 1'b0, 1'b0, 1'b1, 4'd0);
        check("b_wrapdn_q", b_q, 9);
        check("b_wrapdn_tc", b_tc, 1);
        cycle(1, 1'b0, 1'b0, 1'b1, 4'd0);
        check("b_dec_q", b_q, 8);
        check("b_dec_tc", b_tc, 0);
        cycle(1, 1'b1, 1'b0, 1'b0, 4'd12);
        check("b_ld12_q", b_q, 9);
        check("b_ld12_err", b_err, 1);
        cycle(1, 1'b1, 1'b0, 1'b0, 4'd15);
        check("b_ld15_q", b_q, 9);
        check("b_ld15_err", b_err, 1);
        cycle(1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("b_idle_q", b_q, 9);
        check("b_idle_err", b_err, 0);
        cycle(1, 1'b1, 1'b1, 1'b0, 4'd3);
        check("b_ldinc_q", b_q, 3);
        check("b_ldinc_tc", b_tc, 0);
        check("b_ldinc_err", b_err, 0);

        // Modulus 10, saturate mode: twelve increments from 0 against the model.
        cycle(2, 1'b1, 1'b0, 1'b0, 4'd0);
        check("c_ld0", c_q, 0);
        exp_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle(2, 1'b0, 1'b1, 1'b0, 4'd0);
            m       = cnt_next(exp_cnt, 1'b1, 1'b0, 64'd10, CNT_SAT);
            exp_cnt = m.count;
            check($sformatf("c_inc_q%0d", k), c_q, exp_cnt);
            check($sformatf("c_inc_tc%0d", k), c_tc, m.tc);
        end
        check("c_sat_top", c_q, 9);
        check("c_sat_tc", c_tc, 1);
        cycle(2, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(2, 1'b0, 1'b0, 1'b1, 4'd0);
        check("c_satdn_q", c_q, 0);
        check("c_satdn_tc", c_tc, 1);

        // Mid-count asynchronous reset: load 6 into a, raise c's tc, then reset between edges.
        @(negedge clk);
        {a_ld, a_inc, a_dec} = 3'b100; a_din = 3'd6;
        {b_ld, b_inc, b_dec} = 3'b000;
        {c_ld, c_inc, c_dec} = 3'b001;
        @(posedge clk);
        #1;
        check("a_pre_rst_q", a_q, 6);
        check("c_pre_rst_tc", c_tc, 1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_a_q", a_q, 0);
        check("async_rst_c_tc", c_tc, 0);
        check("async_rst_b_q", b_q, 0);
        @(negedge clk);
        {a_ld, a_inc, a_dec} = 3'b000;
        {c_ld, c_inc, c_dec} = 3'b000;
        rst = 1'b1;
        cycle(0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("post_rst_a_q", a_q, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised successor to the fixed 3-bit load/increment counter. Adds configurable width and modulus, a decrement input, a selectable wrap or saturate mode, and registered terminal-count and load-error flags. It sits in the chapter's example DUT set as the counter that test benches drive and check with assertions.

## Interface

Parameters:
- `WIDTH`, 3: counter width in bits (≥ 1).
- `MODULUS`, 2**WIDTH: count range is 0 .. MODULUS-1. Constraint: 2 ≤ MODULUS ≤ 2**WIDTH.
- `SATURATE`, 0: 0 = wrap at the range ends, 1 = hold at the range ends.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `ld`  in  1  load `data_in` on the next edge; highest priority.
- `inc`  in  1  count up.
- `dec`  in  1  count down.
- `data_in`  in  WIDTH  load value.
- `data_out`  out  WIDTH  current count, registered.
- `tc`  out  1  one-cycle pulse when a step crosses or hits a range end (wrap or saturation attempt).
- `ld_err`  out  1  one-cycle pulse when a load value is out of range.

## Operation

Priority per edge: `ld` first, then `inc`/`dec`, then hold.
- `ld`=1:
  - `data_in` < MODULUS: `data_out` ← `data_in`, and `ld_err` ← 0.
  - Otherwise: `data_out` ← MODULUS-1, and `ld_err` ← 1.
  - `inc` and `dec` are ignored. `tc` ← 0.
- `ld`=0, `inc`=1, `dec`=0:
  - `data_out` < MODULUS-1: increment by 1, `tc` ← 0.
  - `data_out` = MODULUS-1, SATURATE=0: → 0, `tc` ← 1.
  - `data_out` = MODULUS-1, SATURATE=1: hold, `tc` ← 1.
- `ld`=0, `dec`=1, `inc`=0:
  - `data_out` > 0: decrement by 1, `tc` ← 0.
  - `data_out` = 0, SATURATE=0: → MODULUS-1, `tc` ← 1.
  - `data_out` = 0, SATURATE=1: hold, `tc` ← 1.
- `inc`=`dec`=1 with `ld`=0: hold; `tc` ← 0, `ld_err` ← 0.
- No request: hold; `tc` ← 0, `ld_err` ← 0.
- Arithmetic:
  - Done in WIDTH+1 bits internally; compare against MODULUS-1, never rely on natural overflow.
  - When MODULUS = 2**WIDTH, behaviour is identical to natural binary wrap.
- Unknown (X) on `ld`/`inc`/`dec` is a bench error, not handled.

## Timing

- Reset: `rst`=0 asynchronously forces `data_out`=0, `tc`=0, `ld_err`=0, regardless of `clk`.
- Release: the first posedge after `rst` rises acts normally. The bench deasserts reset on a negedge.
- Latency: one cycle. Inputs sampled at posedge N appear on `data_out`, `tc` and `ld_err` after posedge N.
- Outputs come straight from registers, with no combinational path from inputs.
- `tc` and `ld_err` are high for exactly one cycle per triggering edge. Consecutive triggering edges keep them high on consecutive cycles.
- Reset mid-count: the count is lost immediately and the flags clear in the same time step.

## Structure

- Shared package `counter_pkg`:
  - mode constants `CNT_WRAP`=0 and `CNT_SAT`=1;
  - a function computing next-count and `tc` from (count, up, down, MODULUS, mode), reused by the bench's reference model.
- No sub-module. A single always block handles reset and the registers; the next-state logic sits in one combinational block or the package function.
- Elaboration-time check: `$error` if MODULUS < 2 or MODULUS > 2**WIDTH.

## Test plan

- Defaults (WIDTH=3), reset released on negedge, `inc`=1 for 10 cycles → `data_out` 0,1,…,7,0,1,2; `tc` high only on the cycle `data_out` goes 7→0.
- WIDTH=4, MODULUS=10, SATURATE=0: `ld` 9 then `inc` → 0 with `tc`=1; `dec` from 0 → 9 with `tc`=1.
- WIDTH=4, MODULUS=10, SATURATE=1: `inc` ×12 from 0 → stops at 9, `tc` high on each attempt at 9; `dec` at 0 → stays 0, `tc`=1.
- WIDTH=4, MODULUS=10: `ld`=1, `data_in`=12 → `data_out`=9, `ld_err`=1 for one cycle. `ld`=1, `inc`=1, `data_in`=3 → `data_out`=3, no increment.
- Any config: `inc`=`dec`=1 at count 5 → holds 5, `tc`=0.
- Any config: `rst` pulled low between edges at count 6 → `data_out`=0 immediately, before the next edge.
